// File: rtl/mm_bus_unit.sv
// ---------------------------------------------------------------------------
// mm_bus_unit -- MEM-stage access unit between EX and WB.
//
// Accepts one load or store from EX, runs it on a word-wide req/ack bus with
// byte enables, and holds the pipeline (stall) until the bus acknowledges.
// Handles byte, half, word, left-word (LWL/SWL) and right-word (LWR/SWR)
// accesses. Misaligned half/word ops are rejected with a one-cycle
// alignment_err pulse. A bus that never acknowledges is abandoned after
// TIMEOUT BUSY cycles and reported with a one-cycle bus_err pulse. An
// exception flush kills an op that has not started; an op already on the bus
// runs to completion, but its result is not reported.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    exception flush
//   req_valid                EX presents an op this cycle
//   mem_access_type          00/11 none, 01 load, 10 store
//   mem_access_size          0 byte, 1 half, 2 word, 3 left-word, 4 right-word
//   mem_access_signed        sign-extend byte/half loads
//   addr_i, data_i           effective address, store data / ALU result / merge base
//   reg_addr_from_ex         destination register
//   mem_access_ack           bus completes the access this cycle
//   mem_access_data_in       bus read data, valid with ack
//   stall                    hold EX/ID/IF (combinational)
//   data_o, bypass_reg_addr_mm, result_valid   registered result to WB/bypass
//   alignment_err, bus_err   one-cycle error pulses
//   mem_access_addr/_data_out/_byte_en/_read/_write   registered bus request
// ---------------------------------------------------------------------------
module mm_bus_unit #(
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [1:0]        mem_access_type,
  input  logic [2:0]        mem_access_size,
  input  logic              mem_access_signed,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [4:0]        reg_addr_from_ex,
  input  logic              mem_access_ack,
  input  logic [31:0]       mem_access_data_in,
  output logic              stall,
  output logic [31:0]       data_o,
  output logic [4:0]        bypass_reg_addr_mm,
  output logic              result_valid,
  output logic              alignment_err,
  output logic              bus_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [31:0]       mem_access_data_out,
  output logic [3:0]        mem_access_byte_en,
  output logic              mem_access_read,
  output logic              mem_access_write
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam bit TO_EN = (TIMEOUT > 0);
  // Last count value before expiry; the counter holds the number of BUSY
  // cycles already spent without ack.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = (TIMEOUT > 0) ? TIMEOUT_W'(TIMEOUT - 1) : '0;

  state_t                state_q, state_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic                  flushed_q, flushed_d;
  logic                  is_load_q, is_load_d;
  logic [2:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [1:0]            a_q, a_d;
  logic [31:0]           base_q, base_d;
  logic [4:0]            reg_q, reg_d;

  logic [31:0]           data_o_q, data_o_d;
  logic [4:0]            bypass_q, bypass_d;
  logic                  result_valid_q, result_valid_d;
  logic                  alignment_err_q, alignment_err_d;
  logic                  bus_err_q, bus_err_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           dout_q, dout_d;
  logic [3:0]            be_q, be_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;

  // Request decode on the live EX inputs
  logic       mem_op;
  logic [1:0] a_in;
  logic [4:0] sh_in, lsh_in;
  logic       misaligned;
  logic       accept;
  logic [3:0] be_in;
  logic [31:0] dout_in;

  assign mem_op     = (mem_access_type == 2'b01) || (mem_access_type == 2'b10);
  assign a_in       = addr_i[1:0];
  assign sh_in      = {a_in, 3'b000};
  assign lsh_in     = {2'd3 - a_in, 3'b000};
  assign misaligned = ((mem_access_size == 3'd1) && a_in[0]) ||
                      ((mem_access_size == 3'd2) && (a_in != 2'b00));
  assign accept     = (state_q == IDLE) && req_valid && !flush && mem_op && !misaligned;

  always_comb begin
    be_in   = 4'b1111;
    dout_in = data_i;
    case (mem_access_size)
      3'd0: begin
        be_in   = 4'b0001 << a_in;
        dout_in = {4{data_i[7:0]}};
      end
      3'd1: begin
        be_in   = a_in[1] ? 4'b1100 : 4'b0011;
        dout_in = {2{data_i[15:0]}};
      end
      3'd3: begin
        be_in   = 4'b1111 >> (2'd3 - a_in);
        dout_in = data_i >> lsh_in;
      end
      3'd4: begin
        be_in   = 4'b1111 << a_in;
        dout_in = data_i << sh_in;
      end
      default: begin
        be_in   = 4'b1111;
        dout_in = data_i;
      end
    endcase
  end

  // Read data split into byte lanes for byte extraction
  logic [7:0] m_lane [4];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign m_lane[gi] = mem_access_data_in[8*gi +: 8];
    end
  endgenerate

  // Load result formatting from the latched op and the live read data
  logic [4:0]  sh_q, lsh_q;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_fmt;

  assign sh_q     = {a_q, 3'b000};
  assign lsh_q    = {2'd3 - a_q, 3'b000};
  assign byte_val = m_lane[a_q];
  assign half_val = a_q[1] ? mem_access_data_in[31:16] : mem_access_data_in[15:0];

  always_comb begin
    case (size_q)
      3'd0:    load_fmt = {{24{signed_q & byte_val[7]}}, byte_val};
      3'd1:    load_fmt = {{16{signed_q & half_val[15]}}, half_val};
      3'd3:    load_fmt = (mem_access_data_in << lsh_q) | (base_q & ~(32'hFFFF_FFFF << lsh_q));
      3'd4:    load_fmt = (mem_access_data_in >> sh_q) | (base_q & ~(32'hFFFF_FFFF >> sh_q));
      default: load_fmt = mem_access_data_in;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    flushed_d       = flushed_q;
    is_load_d       = is_load_q;
    size_d          = size_q;
    signed_d        = signed_q;
    a_d             = a_q;
    base_d          = base_q;
    reg_d           = reg_q;
    data_o_d        = data_o_q;
    bypass_d        = bypass_q;
    result_valid_d  = 1'b0;
    alignment_err_d = 1'b0;
    bus_err_d       = 1'b0;
    addr_d          = addr_q;
    dout_d          = dout_q;
    be_d            = be_q;
    read_d          = read_q;
    write_d         = write_q;

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          if (!mem_op) begin
            // Non-memory op passes straight through to WB
            data_o_d       = data_i;
            bypass_d       = reg_addr_from_ex;
            result_valid_d = 1'b1;
          end else if (misaligned) begin
            alignment_err_d = 1'b1;
          end else begin
            state_d   = BUSY;
            cnt_d     = '0;
            flushed_d = 1'b0;
            is_load_d = (mem_access_type == 2'b01);
            size_d    = mem_access_size;
            signed_d  = mem_access_signed;
            a_d       = a_in;
            base_d    = data_i;
            reg_d     = reg_addr_from_ex;
            addr_d    = {addr_i[ADDR_W-1:2], 2'b00};
            be_d      = be_in;
            dout_d    = (mem_access_type == 2'b10) ? dout_in : 32'h0;
            read_d    = (mem_access_type == 2'b01);
            write_d   = (mem_access_type == 2'b10);
          end
        end
      end
      BUSY: begin
        if (flush) flushed_d = 1'b1;
        if (mem_access_ack) begin
          // Ack wins over a timeout expiring in the same cycle
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = DONE;
          if (!(flushed_q || flush)) begin
            data_o_d       = is_load_q ? load_fmt : base_q;
            bypass_d       = reg_q;
            result_valid_d = 1'b1;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          read_d    = 1'b0;
          write_d   = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          flushed_d = 1'b0;
        end else if (TO_EN) begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      DONE: begin
        state_d   = IDLE;
        flushed_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      flushed_q       <= 1'b0;
      is_load_q       <= 1'b0;
      size_q          <= 3'd0;
      signed_q        <= 1'b0;
      a_q             <= 2'b00;
      base_q          <= 32'h0;
      reg_q           <= 5'd0;
      data_o_q        <= 32'h0;
      bypass_q        <= 5'd0;
      result_valid_q  <= 1'b0;
      alignment_err_q <= 1'b0;
      bus_err_q       <= 1'b0;
      addr_q          <= '0;
      dout_q          <= 32'h0;
      be_q            <= 4'b0000;
      read_q          <= 1'b0;
      write_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      flushed_q       <= flushed_d;
      is_load_q       <= is_load_d;
      size_q          <= size_d;
      signed_q        <= signed_d;
      a_q             <= a_d;
      base_q          <= base_d;
      reg_q           <= reg_d;
      data_o_q        <= data_o_d;
      bypass_q        <= bypass_d;
      result_valid_q  <= result_valid_d;
      alignment_err_q <= alignment_err_d;
      bus_err_q       <= bus_err_d;
      addr_q          <= addr_d;
      dout_q          <= dout_d;
      be_q            <= be_d;
      read_q          <= read_d;
      write_q         <= write_d;
    end
  end

  assign stall               = accept || (state_q == BUSY);
  assign data_o              = data_o_q;
  assign bypass_reg_addr_mm  = bypass_q;
  assign result_valid        = result_valid_q;
  assign alignment_err       = alignment_err_q;
  assign bus_err             = bus_err_q;
  assign mem_access_addr     = addr_q;
  assign mem_access_data_out = dout_q;
  assign mem_access_byte_en  = be_q;
  assign mem_access_read     = read_q;
  assign mem_access_write    = write_q;

endmodule
